// File: rtl/fetch_pipe_ctrl.sv
// Stall/flush controller for the IF->ID pipeline-register chain. It tracks a valid bit per stage,
// collapses bubbles under decode stall, and sequences i-cache miss waits and mispredict redirects.
module fetch_pipe_ctrl #(
  parameter int unsigned NUM_STAGES       = 5,
  parameter int unsigned REDIRECT_BUBBLES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ID_STALL,
  input  logic                  ICACHE_MISS,
  input  logic                  ICACHE_READY,
  input  logic                  MISPREDICT,
  input  logic [31:0]           MISPREDICT_TARGET,
  output logic [NUM_STAGES-1:0] STAGE_STALL,
  output logic [NUM_STAGES-1:0] STAGE_FLUSH,
  output logic                  FETCH_VALID,
  output logic                  FETCH_STALL,
  output logic                  PC_SEL,
  output logic [31:0]           REDIRECT_PC,
  output logic [1:0]            STATE,
  output logic [15:0]           MISS_CYCLES,
  output logic [15:0]           FLUSH_COUNT
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MISS     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic [NUM_STAGES-1:0] hold;
  logic [3:0]            bubble_q, bubble_d;
  logic [31:0]           redirect_pc_q, redirect_pc_d;
  logic                  pc_sel_q, pc_sel_d;
  logic [15:0]           miss_cycles_q, miss_cycles_d;
  logic [15:0]           flush_count_q, flush_count_d;
  logic                  fetch_valid;

  // Hold ripples upstream from ID only through valid stages, so a bubble absorbs the stall.
  always_comb begin
    hold = '0;
    hold[NUM_STAGES-1] = ID_STALL & valid_q[NUM_STAGES-1];
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      hold[NUM_STAGES-1-i] = hold[NUM_STAGES-i] & valid_q[NUM_STAGES-1-i];
    end
  end

  assign fetch_valid = (state_q == ST_RUN) & ~ICACHE_MISS & ~MISPREDICT;

  always_comb begin
    valid_d = '0;
    if (!MISPREDICT) begin
      valid_d[0] = hold[0] ? valid_q[0] : fetch_valid;
      for (int unsigned i = 1; i < NUM_STAGES; i++) begin
        valid_d[i] = hold[i] ? valid_q[i] : valid_q[i-1];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    bubble_d      = bubble_q;
    redirect_pc_d = redirect_pc_q;
    pc_sel_d      = 1'b0;
    miss_cycles_d = miss_cycles_q;
    flush_count_d = flush_count_q;

    if (state_q == ST_MISS && miss_cycles_q != '1) begin
      miss_cycles_d = miss_cycles_q + 16'd1;
    end

    if (MISPREDICT) begin
      state_d       = ST_REDIRECT;
      bubble_d      = 4'(REDIRECT_BUBBLES);
      redirect_pc_d = MISPREDICT_TARGET;
      pc_sel_d      = 1'b1;
      if (flush_count_q != '1) begin
        flush_count_d = flush_count_q + 16'd1;
      end
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (ICACHE_MISS) state_d = ST_MISS;
        end
        ST_MISS: begin
          if (ICACHE_READY) state_d = ST_RUN;
        end
        ST_REDIRECT: begin
          bubble_d = bubble_q - 4'd1;
          if (bubble_q == 4'd1) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q       <= ST_RUN;
      valid_q       <= '0;
      bubble_q      <= '0;
      redirect_pc_q <= '0;
      pc_sel_q      <= 1'b0;
      miss_cycles_q <= '0;
      flush_count_q <= '0;
    end else begin
      state_q       <= state_d;
      valid_q       <= valid_d;
      bubble_q      <= bubble_d;
      redirect_pc_q <= redirect_pc_d;
      pc_sel_q      <= pc_sel_d;
      miss_cycles_q <= miss_cycles_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign STAGE_STALL = (RESET & ~MISPREDICT) ? hold : '0;
  assign STAGE_FLUSH = {NUM_STAGES{RESET & MISPREDICT}};
  assign FETCH_VALID = RESET & fetch_valid;
  assign FETCH_STALL = RESET & (hold[0] | ~fetch_valid);
  assign PC_SEL      = pc_sel_q;
  assign REDIRECT_PC = redirect_pc_q;
  assign STATE       = state_q;
  assign MISS_CYCLES = miss_cycles_q;
  assign FLUSH_COUNT = flush_count_q;

endmodule

// File: tb/tb_fetch_pipe_ctrl.sv
// Scoreboard bench for fetch_pipe_ctrl: stimulus queues hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_pipe_ctrl;

  localparam logic [1:0] S_RUN = 2'd0, S_MISS = 2'd1, S_RED = 2'd2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        ID_STALL = 1'b0, ICACHE_MISS = 1'b0, ICACHE_READY = 1'b0, MISPREDICT = 1'b0;
  logic [31:0] MISPREDICT_TARGET = '0;
  logic [4:0]  STAGE_STALL, STAGE_FLUSH;
  logic        FETCH_VALID, FETCH_STALL, PC_SEL;
  logic [31:0] REDIRECT_PC;
  logic [1:0]  STATE;
  logic [15:0] MISS_CYCLES, FLUSH_COUNT;

  fetch_pipe_ctrl #(.NUM_STAGES(5), .REDIRECT_BUBBLES(2)) dut (
    .CLK(CLK), .RESET(RESET), .ID_STALL(ID_STALL), .ICACHE_MISS(ICACHE_MISS),
    .ICACHE_READY(ICACHE_READY), .MISPREDICT(MISPREDICT), .MISPREDICT_TARGET(MISPREDICT_TARGET),
    .STAGE_STALL(STAGE_STALL), .STAGE_FLUSH(STAGE_FLUSH), .FETCH_VALID(FETCH_VALID),
    .FETCH_STALL(FETCH_STALL), .PC_SEL(PC_SEL), .REDIRECT_PC(REDIRECT_PC), .STATE(STATE),
    .MISS_CYCLES(MISS_CYCLES), .FLUSH_COUNT(FLUSH_COUNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    string       name;
    logic [4:0]  stall, flush;
    logic        fv, fs, pcsel;
    logic [1:0]  state;
    logic [31:0] rpc;
    logic [15:0] miss, fc;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          failed = 0;
  logic [31:0] exp_rpc = '0;
  logic [15:0] exp_miss = '0, exp_fc = '0;

  function automatic void chk(string nm, string fld, logic [31:0] act, logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s %s: got %h expected %h", nm, fld, act, expv);
    end
  endfunction

  always @(negedge CLK) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk(e.name, "STAGE_STALL", 32'(STAGE_STALL), 32'(e.stall));
      chk(e.name, "STAGE_FLUSH", 32'(STAGE_FLUSH), 32'(e.flush));
      chk(e.name, "FETCH_VALID", 32'(FETCH_VALID), 32'(e.fv));
      chk(e.name, "FETCH_STALL", 32'(FETCH_STALL), 32'(e.fs));
      chk(e.name, "PC_SEL",      32'(PC_SEL),      32'(e.pcsel));
      chk(e.name, "STATE",       32'(STATE),       32'(e.state));
      chk(e.name, "REDIRECT_PC", REDIRECT_PC,      e.rpc);
      chk(e.name, "MISS_CYCLES", 32'(MISS_CYCLES), 32'(e.miss));
      chk(e.name, "FLUSH_COUNT", 32'(FLUSH_COUNT), 32'(e.fc));
    end
  end

  task automatic step(input string nm, input bit rst, input bit ids, input bit icm, input bit rdy,
                      input bit mp, input logic [31:0] tgt, input logic [4:0] e_stall,
                      input logic [4:0] e_flush, input bit e_fv, input bit e_fs, input bit e_pcsel,
                      input logic [1:0] e_state);
    exp_t e;
    @(posedge CLK);
    #1;
    RESET = rst; ID_STALL = ids; ICACHE_MISS = icm; ICACHE_READY = rdy;
    MISPREDICT = mp; MISPREDICT_TARGET = tgt;
    e.name = nm; e.stall = e_stall; e.flush = e_flush; e.fv = e_fv; e.fs = e_fs;
    e.pcsel = e_pcsel; e.state = e_state; e.rpc = exp_rpc; e.miss = exp_miss; e.fc = exp_fc;
    sb.push_back(e);
  endtask

  initial begin
    // Reset: combinational outputs forced low even with MISPREDICT/ICACHE_MISS asserted
    step("reset", 0, 1, 1, 0, 1, 32'hFFFF_FFFF, 5'b00000, 5'b00000, 0, 0, 0, S_RUN);
    step("release", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 1, 0, 0, S_RUN);
    for (int i = 0; i < 10; i++)
      step("run", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 1, 0, 0, S_RUN);

    // Full pipe under decode stall
    for (int i = 0; i < 3; i++)
      step("full_stall", 1, 1, 0, 0, 0, '0, 5'b11111, 5'b00000, 1, 1, 0, S_RUN);
    step("stall_release", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 1, 0, 0, S_RUN);

    // Miss with READY in the same RUN cycle; READY only counts from the next cycle
    step("miss_enter", 1, 0, 1, 1, 0, '0, 5'b00000, 5'b00000, 0, 1, 0, S_RUN);
    for (int i = 0; i < 3; i++) begin
      step("miss_wait", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 0, 1, 0, S_MISS);
      exp_miss = exp_miss + 16'd1;
    end
    step("miss_ready", 1, 0, 0, 1, 0, '0, 5'b00000, 5'b00000, 0, 1, 0, S_MISS);
    exp_miss = 16'd4;
    for (int i = 0; i < 5; i++)
      step("refill", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 1, 0, 0, S_RUN);
    step("refull_stall", 1, 1, 0, 0, 0, '0, 5'b11111, 5'b00000, 1, 1, 0, S_RUN);

    // Short miss leaves two bubbles; decode stall then collapses them
    step("bub_miss", 1, 0, 1, 0, 0, '0, 5'b00000, 5'b00000, 0, 1, 0, S_RUN);
    step("bub_ready", 1, 0, 0, 1, 0, '0, 5'b00000, 5'b00000, 0, 1, 0, S_MISS);
    exp_miss = 16'd5;
    step("bub_adv", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 1, 0, 0, S_RUN);
    step("bub_st_11001", 1, 1, 0, 0, 0, '0, 5'b11000, 5'b00000, 1, 0, 0, S_RUN);
    step("bub_st_11011", 1, 1, 0, 0, 0, '0, 5'b11000, 5'b00000, 1, 0, 0, S_RUN);
    step("bub_filled", 1, 1, 0, 0, 0, '0, 5'b11111, 5'b00000, 1, 1, 0, S_RUN);

    // Mispredict on a full, stalled pipe
    step("mp_flush", 1, 1, 0, 0, 1, 32'h0040_0100, 5'b00000, 5'b11111, 0, 1, 0, S_RUN);
    exp_rpc = 32'h0040_0100; exp_fc = 16'd1;
    step("mp_pcsel", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 0, 1, 1, S_RED);
    step("mp_red2_icm", 1, 0, 1, 0, 0, '0, 5'b00000, 5'b00000, 0, 1, 0, S_RED);
    step("mp_run", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 1, 0, 0, S_RUN);

    // Second mispredict in the first REDIRECT cycle reloads the bubble counter
    step("mp2_a", 1, 0, 0, 0, 1, 32'h1234_5678, 5'b00000, 5'b11111, 0, 1, 0, S_RUN);
    exp_rpc = 32'h1234_5678; exp_fc = 16'd2;
    step("mp2_b", 1, 0, 0, 0, 1, 32'hDEAD_BEE0, 5'b00000, 5'b11111, 0, 1, 1, S_RED);
    exp_rpc = 32'hDEAD_BEE0; exp_fc = 16'd3;
    step("mp2_pcsel", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 0, 1, 1, S_RED);
    step("mp2_reload", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 0, 1, 0, S_RED);
    step("mp2_run", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 1, 0, 0, S_RUN);

    // Mispredict abandons a miss
    step("mm_miss", 1, 0, 1, 0, 0, '0, 5'b00000, 5'b00000, 0, 1, 0, S_RUN);
    step("mm_mp", 1, 0, 0, 0, 1, 32'h0000_0040, 5'b00000, 5'b11111, 0, 1, 0, S_MISS);
    exp_rpc = 32'h0000_0040; exp_fc = 16'd4; exp_miss = 16'd6;
    step("mm_red1", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 0, 1, 1, S_RED);
    step("mm_red2_rdy", 1, 0, 0, 1, 0, '0, 5'b00000, 5'b00000, 0, 1, 0, S_RED);
    step("mm_run", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 1, 0, 0, S_RUN);

    // Reset asserted while PC_SEL is pending
    step("rr_mp", 1, 0, 0, 0, 1, 32'hCAFE_0000, 5'b00000, 5'b11111, 0, 1, 0, S_RUN);
    exp_rpc = '0; exp_fc = '0; exp_miss = '0;
    step("rr_reset", 0, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 0, 0, 0, S_RUN);
    step("rr_release", 1, 0, 0, 0, 0, '0, 5'b00000, 5'b00000, 1, 0, 0, S_RUN);

    @(negedge CLK);
    #1;
    tests++;
    if (sb.size() != 0) begin
      failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_pipe_ctrl.md
# fetch_pipe_ctrl

Stall/flush controller for the chain of fetch-side pipeline registers between IF and ID in the branch-predictor front end. Tracks a valid bit per pipeline-register stage, drives each stage's STALL input so bubbles collapse under a decode stall, and sequences instruction-cache miss waits and branch-mispredict redirects. It also keeps saturating performance counters for miss and flush events.

## Interface
- NUM_STAGES, 5, number of pipeline-register stages controlled; stage 0 is fed by IF, stage NUM_STAGES-1 feeds ID; legal range 1..8.
- REDIRECT_BUBBLES, 2, cycles spent in REDIRECT after a mispredict; legal range 1..15.

- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- ID_STALL  in  1  decode cannot accept the instruction from stage NUM_STAGES-1 this cycle.
- ICACHE_MISS  in  1  the instruction at the current fetch PC is not available this cycle.
- ICACHE_READY  in  1  miss fill complete; sampled only in MISS.
- MISPREDICT  in  1  a branch resolved as mispredicted; flush the whole front end.
- MISPREDICT_TARGET  in  32  correct PC; valid only when MISPREDICT=1.
- STAGE_STALL  out  NUM_STAGES  per-stage STALL; bit i drives stage i.
- STAGE_FLUSH  out  NUM_STAGES  per-stage clear-to-NOP; bit i drives stage i.
- FETCH_VALID  out  1  IF presents a valid instruction into stage 0 this cycle.
- FETCH_STALL  out  1  IF holds its PC this cycle.
- PC_SEL  out  1  IF loads REDIRECT_PC; overrides FETCH_STALL.
- REDIRECT_PC  out  32  registered redirect target.
- STATE  out  2  debug view: 0 RUN, 1 MISS, 2 REDIRECT.
- MISS_CYCLES  out  16  saturating count of cycles spent in MISS.
- FLUSH_COUNT  out  16  saturating count of accepted mispredicts.

## Operation
- Reset (RESET=0): valid[] = 0, STATE = RUN, bubble counter = 0, REDIRECT_PC = 0, PC_SEL = 0, MISS_CYCLES = 0, FLUSH_COUNT = 0. Combinational outputs are forced to 0 while RESET=0.
- Hold chain (combinational):
  - hold[N-1] = ID_STALL & valid[N-1].
  - hold[i] = hold[i+1] & valid[i].
  - An invalid stage never stalls; its bubble is overwritten.
  - STAGE_STALL = hold when MISPREDICT=0, else all zeros.
- FETCH_VALID = (STATE==RUN) & !ICACHE_MISS & !MISPREDICT.
- FETCH_STALL = hold[0] | !FETCH_VALID.
- Valid update when MISPREDICT=0:
  - A held stage keeps its valid bit.
  - Otherwise valid[0] <= FETCH_VALID and valid[i] <= valid[i-1].
- STAGE_FLUSH = {NUM_STAGES{MISPREDICT}}. On MISPREDICT all valid bits clear at the next edge.
- State machine:
  - RUN: ICACHE_MISS=1 → MISS.
  - MISS: ICACHE_READY=1 → RUN. MISS_CYCLES increments each cycle spent in MISS, saturating at 0xFFFF.
  - REDIRECT: the bubble counter decrements each cycle; when the counter equals 1 → RUN. ICACHE_MISS is ignored in REDIRECT.
  - MISPREDICT=1 in any state, including REDIRECT and MISS:
    - next state is REDIRECT;
    - bubble counter loads REDIRECT_BUBBLES;
    - REDIRECT_PC loads MISPREDICT_TARGET;
    - PC_SEL is 1 for exactly the next cycle;
    - FLUSH_COUNT increments, saturating at 0xFFFF.
- Priority: MISPREDICT > ICACHE_READY/ICACHE_MISS > ID_STALL.
- A MISPREDICT during MISS abandons the miss.

## Timing
- Mispredict at edge k:
  - flush is visible combinationally in cycle k;
  - PC_SEL=1 in cycle k+1;
  - FETCH_VALID=0 for REDIRECT_BUBBLES cycles, k+1 .. k+REDIRECT_BUBBLES;
  - first refetched instruction enters stage 0 at the end of cycle k+REDIRECT_BUBBLES+1, if ICACHE_MISS=0.
- Empty-pipe latency: an instruction fetched in cycle t is presented to ID in cycle t+NUM_STAGES.
- ID_STALL with a full pipe: every stage is held in the same cycle, and nothing is lost or duplicated.
- ID_STALL with bubbles: only the stages downstream of the youngest bubble hold; upstream stages advance into the bubble.
- ICACHE_MISS and ICACHE_READY asserted in the same cycle while in RUN: the block enters MISS. READY is honored only from the next cycle on.
- Reset asserted mid-redirect or mid-miss: returns immediately to the reset values. There is no residual PC_SEL.

## Test plan
- Reset, then 10 cycles in RUN with no stalls. After 5 cycles all valid bits are 1, STAGE_STALL=0, and FETCH_VALID=1 throughout.
- Full pipe, ID_STALL=1 for 3 cycles. STAGE_STALL=5'b11111 in each of those cycles; after release each stage's contents advance exactly once per cycle.
- Bubble at stage 2, ID_STALL=1. STAGE_STALL=5'b11000; stages 0-1 advance and the bubble is filled after 1 cycle.
- ICACHE_MISS for 1 cycle, then ICACHE_READY after 4 cycles in MISS. STATE=MISS for 4 cycles, MISS_CYCLES=4, FETCH_STALL=1 throughout.
- MISPREDICT with target 0x00400100 while the pipe is full and ID_STALL=1. STAGE_FLUSH=5'b11111 and STAGE_STALL=0 that cycle, PC_SEL=1 with REDIRECT_PC=0x00400100 the next cycle, then 2 REDIRECT cycles, and FLUSH_COUNT=1.
- Second MISPREDICT in the first REDIRECT cycle. The bubble counter reloads to 2, REDIRECT_PC updates to the new target, and FLUSH_COUNT=2.
